// File: rtl/mem_arb_pkg.sv
// Shared types and index helper for the memory port arbiter.
// Pure declarations: no latency, no flow control of its own.
package mem_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   // Circular port index: (base + off) wrapped into 0..n-1.
   function automatic int wrap_idx(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational grant picker: round-robin from ptr, or lowest index in fixed mode.
// Zero latency; grant_vld is low when no port requests.
module rr_grant
   import mem_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int PTR_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PTR_W-1:0]     ptr,
   input  arb_mode_e            mode,
   output logic [NUM_PORTS-1:0] grant,
   output logic [PTR_W-1:0]     grant_idx,
   output logic                 grant_vld
);

   logic [PTR_W-1:0] cand;

   // Walk the ports in priority order; the first requester wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      cand      = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = PTR_W'(wrap_idx((mode == ARB_FIXED) ? 0 : int'(ptr), i, NUM_PORTS));
         if (!grant_vld && req[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = cand;
            grant_vld   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges NUM_PORTS request ports onto one memory port; strobe one cycle after grant, resp same cycle as mem_resp.
// One transaction outstanding; requesters hold until their resp pulse, then one idle cycle separates transactions.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_PORTS     = 2,
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int PRIORITY_MODE = 0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_PORTS-1:0]                 req_read,
   input  logic [NUM_PORTS-1:0]                 req_write,
   input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]   req_byte_enable,
   input  logic [NUM_PORTS-1:0][ADDR_W-1:0]     req_address,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0]     req_wdata,
   output logic [NUM_PORTS-1:0]                 req_resp,
   output logic [DATA_W-1:0]                    req_rdata,
   output logic                                 mem_read,
   output logic                                 mem_write,
   output logic [DATA_W/8-1:0]                  mem_byte_enable,
   output logic [ADDR_W-1:0]                    mem_address,
   output logic [DATA_W-1:0]                    mem_wdata,
   input  logic                                 mem_resp,
   input  logic [DATA_W-1:0]                    mem_rdata
);

   localparam int        BE_W     = DATA_W / 8;
   localparam int        PTR_W    = $clog2(NUM_PORTS);
   localparam arb_mode_e ARB_MODE = (PRIORITY_MODE == 1) ? ARB_FIXED : ARB_RR;

   arb_state_t           state, state_nxt;
   logic [NUM_PORTS-1:0] req_any;
   logic [NUM_PORTS-1:0] grant;
   logic [NUM_PORTS-1:0] grant_q;
   logic [PTR_W-1:0]     grant_idx;
   logic [PTR_W-1:0]     rr_ptr;
   logic                 grant_vld;
   logic                 take;
   logic                 op_write_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [BE_W-1:0]      be_q;

   assign req_any = req_read | req_write;
   assign take    = (state == IDLE) && grant_vld;

   rr_grant #(
      .NUM_PORTS (NUM_PORTS),
      .PTR_W     (PTR_W)
   ) u_rr_grant (
      .req       (req_any),
      .ptr       (rr_ptr),
      .mode      (ARB_MODE),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Capture the winner's whole request so mem_* never sees req_* directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q    <= '0;
         op_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         rr_ptr     <= '0;
      end else if (take) begin
         grant_q    <= grant;
         op_write_q <= req_write[grant_idx];
         addr_q     <= req_address[grant_idx];
         wdata_q    <= req_wdata[grant_idx];
         be_q       <= req_byte_enable[grant_idx];
         if (ARB_MODE == ARB_RR) begin
            rr_ptr <= PTR_W'(wrap_idx(int'(grant_idx), 1, NUM_PORTS));
         end
      end
   end

   always_comb begin
      state_nxt       = state;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = '0;
      mem_address     = '0;
      mem_wdata       = '0;
      req_resp        = '0;
      req_rdata       = '0;
      case (state)
         IDLE: begin
            if (grant_vld) begin
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            mem_read        = !op_write_q;
            mem_write       = op_write_q;
            mem_byte_enable = be_q;
            mem_address     = addr_q;
            mem_wdata       = wdata_q;
            if (mem_resp) begin
               req_resp  = grant_q;
               req_rdata = mem_rdata;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   resp_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_resp));
   idle_quiet:  assert property (@(posedge clk) disable iff (rst)
                                 (state == IDLE) |-> !(mem_read || mem_write || (|req_resp)));
   rdata_zero:  assert property (@(posedge clk) disable iff (rst)
                                 !(mem_resp && state == BUSY) |-> (req_rdata == '0));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (2-port RR, 2-port fixed, 3-port RR) behind a shared stimulus bus.
// A behavioural arbitration model predicts each grant; memory latency and data are randomised.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [1:0]       sel;
   logic [2:0]       req_read, req_write;
   logic [2:0][3:0]  req_be;
   logic [2:0][31:0] req_addr, req_wdata;
   logic             mem_resp;
   logic [31:0]      mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;
   int model_ptr [0:3];

   logic [1:0] a_rd, a_wr, a_resp, b_rd, b_wr, b_resp;
   logic [2:0] c_rd, c_wr, c_resp;
   logic       a_mresp, b_mresp, c_mresp;
   logic       a_mrd, a_mwr, b_mrd, b_mwr, c_mrd, c_mwr;
   logic [3:0] a_mbe, b_mbe, c_mbe;
   logic [31:0] a_rdata, b_rdata, c_rdata, a_maddr, b_maddr, c_maddr, a_mwdata, b_mwdata, c_mwdata;

   logic [2:0]  o_resp;
   logic [31:0] o_rdata, o_maddr, o_mwdata;
   logic        o_mrd, o_mwr;
   logic [3:0]  o_mbe;

   assign a_rd    = (sel == 2'd0) ? req_read[1:0]  : 2'b00;
   assign a_wr    = (sel == 2'd0) ? req_write[1:0] : 2'b00;
   assign b_rd    = (sel == 2'd1) ? req_read[1:0]  : 2'b00;
   assign b_wr    = (sel == 2'd1) ? req_write[1:0] : 2'b00;
   assign c_rd    = (sel == 2'd2) ? req_read       : 3'b000;
   assign c_wr    = (sel == 2'd2) ? req_write      : 3'b000;
   assign a_mresp = (sel == 2'd0) && mem_resp;
   assign b_mresp = (sel == 2'd1) && mem_resp;
   assign c_mresp = (sel == 2'd2) && mem_resp;

   mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .PRIORITY_MODE(0)) dut_rr2 (
      .clk(clk), .rst(rst), .req_read(a_rd), .req_write(a_wr),
      .req_byte_enable(req_be[1:0]), .req_address(req_addr[1:0]), .req_wdata(req_wdata[1:0]),
      .req_resp(a_resp), .req_rdata(a_rdata), .mem_read(a_mrd), .mem_write(a_mwr),
      .mem_byte_enable(a_mbe), .mem_address(a_maddr), .mem_wdata(a_mwdata),
      .mem_resp(a_mresp), .mem_rdata(mem_rdata));

   mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .PRIORITY_MODE(1)) dut_fx2 (
      .clk(clk), .rst(rst), .req_read(b_rd), .req_write(b_wr),
      .req_byte_enable(req_be[1:0]), .req_address(req_addr[1:0]), .req_wdata(req_wdata[1:0]),
      .req_resp(b_resp), .req_rdata(b_rdata), .mem_read(b_mrd), .mem_write(b_mwr),
      .mem_byte_enable(b_mbe), .mem_address(b_maddr), .mem_wdata(b_mwdata),
      .mem_resp(b_mresp), .mem_rdata(mem_rdata));

   mem_port_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .PRIORITY_MODE(0)) dut_rr3 (
      .clk(clk), .rst(rst), .req_read(c_rd), .req_write(c_wr),
      .req_byte_enable(req_be), .req_address(req_addr), .req_wdata(req_wdata),
      .req_resp(c_resp), .req_rdata(c_rdata), .mem_read(c_mrd), .mem_write(c_mwr),
      .mem_byte_enable(c_mbe), .mem_address(c_maddr), .mem_wdata(c_mwdata),
      .mem_resp(c_mresp), .mem_rdata(mem_rdata));

   always_comb begin
      case (sel)
         2'd0: begin
            o_resp = {1'b0, a_resp}; o_rdata = a_rdata; o_mrd = a_mrd; o_mwr = a_mwr;
            o_mbe = a_mbe; o_maddr = a_maddr; o_mwdata = a_mwdata;
         end
         2'd1: begin
            o_resp = {1'b0, b_resp}; o_rdata = b_rdata; o_mrd = b_mrd; o_mwr = b_mwr;
            o_mbe = b_mbe; o_maddr = b_maddr; o_mwdata = b_mwdata;
         end
         default: begin
            o_resp = c_resp; o_rdata = c_rdata; o_mrd = c_mrd; o_mwr = c_mwr;
            o_mbe = c_mbe; o_maddr = c_maddr; o_mwdata = c_mwdata;
         end
      endcase
   end

   // Reference arbitration: scan ports in circular order starting at ptr (or at 0 when fixed).
   function automatic int model_grant(input logic [2:0] mask, input int ptr, input int n, input bit fixed);
      int p;
      for (int off = 0; off < n; off++) begin
         p = fixed ? off : (ptr + off) % n;
         if (((mask >> p) & 3'b001) != 3'b000) return p;
      end
      return -1;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_read = '0; req_write = '0; mem_resp = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) model_ptr[i] = 0;
   endtask

   // Called just after a negedge with requests in place and the DUT idle; returns in the idle cycle after resp.
   task automatic run_txn(input int lat, input logic [31:0] rd, input bit drop_early, output int gnt);
      int n, g, waited, strobes;
      bit fx;
      logic [1:0] gi;
      logic [2:0] mask, exp_resp;
      logic exp_wr;
      logic [31:0] ea, ew;
      logic [3:0] eb;
      gnt  = -1;
      n    = (sel == 2'd2) ? 3 : 2;
      fx   = (sel == 2'd1);
      mask = (req_read | req_write) & ((n == 3) ? 3'b111 : 3'b011);
      g    = model_grant(mask, model_ptr[sel], n, fx);
      if (g < 0) return;
      if (!fx) model_ptr[sel] = (g + 1) % n;
      gi = 2'(g);
      exp_wr = req_write[gi]; ea = req_addr[gi]; ew = req_wdata[gi]; eb = req_be[gi];
      exp_resp = 3'b001 << g;
      waited = 0;
      #2;
      while (!(o_mrd || o_mwr) && waited < 8) begin
         @(negedge clk); #2;
         waited++;
      end
      n_checks++;
      if (waited !== 1) begin
         n_fail++; $display("FAIL strobe_latency: got %0d cycles want 1", waited);
      end
      if (waited >= 8) begin
         req_read[gi] = 1'b0; req_write[gi] = 1'b0;
         return;
      end
      n_checks++;
      if ({o_mrd, o_mwr} !== {~exp_wr, exp_wr}) begin
         n_fail++; $display("FAIL mem_op: got rd=%0b wr=%0b want wr=%0b", o_mrd, o_mwr, exp_wr);
      end
      n_checks++;
      if (o_maddr !== ea || o_mwdata !== ew || o_mbe !== eb) begin
         n_fail++; $display("FAIL mem_fields: got a=%h d=%h be=%h want a=%h d=%h be=%h", o_maddr, o_mwdata, o_mbe, ea, ew, eb);
      end
      if (drop_early) begin
         req_read[gi] = 1'b0; req_write[gi] = 1'b0;
      end
      strobes = 1;
      for (int k = 1; k < lat; k++) begin
         n_checks++;
         if (o_resp !== 3'b000) begin
            n_fail++; $display("FAIL early_resp: got %b want 000", o_resp);
         end
         @(negedge clk); #2;
         if (o_mrd || o_mwr) strobes++;
         n_checks++;
         if (o_maddr !== ea) begin
            n_fail++; $display("FAIL hold_addr: got %h want %h", o_maddr, ea);
         end
      end
      mem_rdata = rd; mem_resp = 1'b1;
      #1;
      n_checks++;
      if (o_resp !== exp_resp) begin
         n_fail++; $display("FAIL resp_port: got %b want %b", o_resp, exp_resp);
      end
      n_checks++;
      if (o_rdata !== rd) begin
         n_fail++; $display("FAIL resp_rdata: got %h want %h", o_rdata, rd);
      end
      n_checks++;
      if (strobes !== lat) begin
         n_fail++; $display("FAIL strobe_cycles: got %0d want %0d", strobes, lat);
      end
      case (o_resp)
         3'b001:  gnt = 0;
         3'b010:  gnt = 1;
         3'b100:  gnt = 2;
         default: gnt = -1;
      endcase
      @(negedge clk);
      mem_resp = 1'b0; mem_rdata = $urandom;
      req_read[gi] = 1'b0; req_write[gi] = 1'b0;
      #2;
      n_checks++;
      if (o_mrd !== 1'b0 || o_mwr !== 1'b0 || o_resp !== 3'b000 || o_rdata !== 32'h0) begin
         n_fail++; $display("FAIL idle_gap: got rd=%0b wr=%0b resp=%b rdata=%h want all zero", o_mrd, o_mwr, o_resp, o_rdata);
      end
   endtask

   task automatic test_reset();
      mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk); #2;
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         n_checks++;
         if (o_mrd !== 1'b0 || o_mwr !== 1'b0 || o_resp !== 3'b000 || o_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_ctrl[%0d]: got rd=%0b wr=%0b resp=%b rdata=%h want 0", s, o_mrd, o_mwr, o_resp, o_rdata);
         end
         n_checks++;
         if (o_maddr !== 32'h0 || o_mwdata !== 32'h0 || o_mbe !== 4'h0) begin
            n_fail++; $display("FAIL reset_data[%0d]: got a=%h d=%h be=%h want 0", s, o_maddr, o_mwdata, o_mbe);
         end
      end
      sel = 2'd0; mem_resp = 1'b0;
   endtask

   task automatic test_single_read();
      int g;
      do_reset();
      sel = 2'd0;
      req_addr[0] = 32'h0000_0060; req_wdata[0] = $urandom; req_be[0] = 4'hF; req_read[0] = 1'b1;
      run_txn(3, 32'hDEAD_BEEF, 1'b0, g);
      n_checks++;
      if (g !== 0) begin
         n_fail++; $display("FAIL single_read_grant: got %0d want 0", g);
      end
   endtask

   task automatic test_contention_rr();
      int g;
      do_reset();
      sel = 2'd0;
      req_addr[0] = $urandom; req_wdata[0] = $urandom; req_be[0] = 4'hF;
      req_addr[1] = $urandom; req_wdata[1] = 32'h1234_5678; req_be[1] = 4'b0011;
      req_read = 3'b001; req_write = 3'b010;
      for (int i = 0; i < 4; i++) begin
         run_txn(1 + int'($urandom_range(0, 2)), $urandom, 1'b0, g);
         n_checks++;
         if (g !== (i % 2)) begin
            n_fail++; $display("FAIL rr_seq[%0d]: got %0d want %0d", i, g, i % 2);
         end
         req_read[0] = 1'b1; req_write[1] = 1'b1;
      end
      req_read = '0; req_write = '0;
   endtask

   task automatic test_fixed();
      int g;
      do_reset();
      sel = 2'd1;
      req_addr[0] = $urandom; req_addr[1] = $urandom;
      req_read = 3'b011;
      for (int i = 0; i < 4; i++) begin
         run_txn(1 + int'($urandom_range(0, 3)), $urandom, 1'b0, g);
         n_checks++;
         if (g !== ((i < 3) ? 0 : 1)) begin
            n_fail++; $display("FAIL fixed_seq[%0d]: got %0d want %0d", i, g, (i < 3) ? 0 : 1);
         end
         if (i < 2) req_read[0] = 1'b1;
      end
      req_read = '0; req_write = '0;
   endtask

   task automatic test_wrap();
      int g;
      do_reset();
      sel = 2'd2;
      for (int p = 0; p < 3; p++) begin
         req_addr[p] = $urandom; req_wdata[p] = $urandom; req_be[p] = 4'($urandom);
      end
      req_read = 3'b111;
      for (int i = 0; i < 4; i++) begin
         run_txn(1 + int'($urandom_range(0, 2)), $urandom, 1'b0, g);
         n_checks++;
         if (g !== (i % 3)) begin
            n_fail++; $display("FAIL wrap_seq[%0d]: got %0d want %0d", i, g, i % 3);
         end
         req_read = 3'b111;
      end
      req_read = '0; req_write = '0;
   endtask

   task automatic test_reset_mid_busy();
      int g;
      do_reset();
      sel = 2'd0;
      req_addr[0] = 32'h0000_0100; req_read[0] = 1'b1;
      @(negedge clk); #2;
      n_checks++;
      if (o_mrd !== 1'b1) begin
         n_fail++; $display("FAIL midrst_busy: got mem_read=%0b want 1", o_mrd);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (o_mrd !== 1'b0 || o_resp !== 3'b000) begin
         n_fail++; $display("FAIL midrst_abort: got rd=%0b resp=%b want 0", o_mrd, o_resp);
      end
      mem_resp = 1'b1; req_read = '0;
      #1;
      n_checks++;
      if (o_resp !== 3'b000) begin
         n_fail++; $display("FAIL midrst_noresp: got %b want 000", o_resp);
      end
      @(negedge clk);
      rst = 1'b0; mem_resp = 1'b0;
      for (int i = 0; i < 4; i++) model_ptr[i] = 0;
      @(negedge clk); #2;
      n_checks++;
      if (o_mrd !== 1'b0 || o_resp !== 3'b000) begin
         n_fail++; $display("FAIL midrst_idle: got rd=%0b resp=%b want 0", o_mrd, o_resp);
      end
      @(negedge clk);
      req_addr[1] = $urandom; req_read = 3'b011;
      run_txn(2, $urandom, 1'b0, g);
      n_checks++;
      if (g !== 0) begin
         n_fail++; $display("FAIL midrst_regrant: got %0d want 0", g);
      end
      req_read = '0; req_write = '0;
   endtask

   task automatic test_rw_both();
      int g;
      do_reset();
      sel = 2'd0;
      mem_resp = 1'b1; mem_rdata = 32'hCAFE_F00D;
      #2;
      n_checks++;
      if (o_resp !== 3'b000 || o_rdata !== 32'h0) begin
         n_fail++; $display("FAIL spurious_resp: got resp=%b rdata=%h want 0", o_resp, o_rdata);
      end
      @(negedge clk);
      mem_resp = 1'b0;
      #2;
      n_checks++;
      if (o_mrd !== 1'b0 || o_mwr !== 1'b0) begin
         n_fail++; $display("FAIL spurious_start: got rd=%0b wr=%0b want 0", o_mrd, o_mwr);
      end
      req_addr[1] = 32'h0000_0abc; req_wdata[1] = $urandom; req_be[1] = 4'b1010;
      req_read[1] = 1'b1; req_write[1] = 1'b1;
      run_txn(2, $urandom, 1'b0, g);
      n_checks++;
      if (g !== 1) begin
         n_fail++; $display("FAIL rw_both_grant: got %0d want 1", g);
      end
   endtask

   task automatic test_drop_early();
      int g;
      do_reset();
      sel = 2'd0;
      req_addr[1] = $urandom; req_wdata[1] = $urandom; req_be[1] = 4'hF; req_write[1] = 1'b1;
      run_txn(3, $urandom, 1'b1, g);
      n_checks++;
      if (g !== 1) begin
         n_fail++; $display("FAIL drop_early_resp: got %0d want 1", g);
      end
   endtask

   task automatic test_random();
      int g, n, op;
      logic [1:0] pi;
      do_reset();
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         n = (s == 2) ? 3 : 2;
         for (int it = 0; it < 25; it++) begin
            for (int p = 0; p < n; p++) begin
               pi = 2'(p);
               if (!(req_read[pi] || req_write[pi]) && $urandom_range(0, 1) == 1) begin
                  op = int'($urandom_range(1, 3));
                  req_addr[pi] = $urandom; req_wdata[pi] = $urandom; req_be[pi] = 4'($urandom);
                  req_read[pi] = (op & 1) != 0; req_write[pi] = (op & 2) != 0;
               end
            end
            if ((req_read | req_write) == 3'b000) begin
               pi = 2'($urandom_range(0, n - 1));
               req_addr[pi] = $urandom; req_read[pi] = 1'b1;
            end
            run_txn(1 + int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 4) == 0), g);
         end
         req_read = '0; req_write = '0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; sel = 2'd0; req_read = '0; req_write = '0;
      req_be = '0; req_addr = '0; req_wdata = '0; mem_resp = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 4; i++) model_ptr[i] = 0;
      test_reset();
      test_single_read();
      test_contention_rr();
      test_fixed();
      test_wrap();
      test_reset_mid_busy();
      test_rw_both();
      test_drop_early();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
